msdap_serial_receiver: RTL

Upstream stage of the 16-to-24 bit extender in the MSDAP input path. Deserialises the two MSB-first serial audio lines (InputL, InputR), framed by a Frame pulse, into parallel 16-bit samples. Also outputs each channel's sign bit as the pad value for the extender. Results are presented through a registered valid/ready output stage with overrun and framing-error reporting.

---
 rtl/msdap_serial_receiver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/msdap_serial_receiver.sv
// Deserialises MSB-first InputL/InputR words framed by Frame into WORD_W-bit samples plus sign pads.
// Registered valid/ready output stage; 1-cycle latency from LSB capture. Optional sleep via ZERO_DETECT_EN.
// Backpressure: a word that completes while the output is held drops and sets the sticky overrun flag.
module msdap_serial_receiver #(
    parameter int WORD_W     = 16,
    parameter int ZERO_LIMIT = 800
) (
    input  logic              Dclk,
    input  logic              Reset,
    input  logic              enable,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    input  logic              out_ready,
    output logic [WORD_W-1:0] dataL,
    output logic [WORD_W-1:0] dataR,
    output logic              padL,
    output logic              padR,
    output logic              out_valid,
    output logic              frame_err,
`ifdef ZERO_DETECT_EN
    output logic              sleep,
`endif
    output logic              overrun
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, stateNext;
    logic [CNT_W-1:0]  bitCnt, bitCntNext;
    logic [WORD_W-1:0] shiftL, shiftR, shiftLNext, shiftRNext;
    logic              wordDone;
    logic              resync;
    logic              loadWord;

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftLNext = shiftL;
        shiftRNext = shiftR;
        wordDone   = 1'b0;
        resync     = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (Frame) begin
                        shiftLNext = {{(WORD_W-1){1'b0}}, InputL};
                        shiftRNext = {{(WORD_W-1){1'b0}}, InputR};
                        bitCntNext = CNT_W'(1);
                        stateNext  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (Frame) begin
                        // Frame mid-word: drop the partial word and restart on this MSB
                        resync     = 1'b1;
                        shiftLNext = {{(WORD_W-1){1'b0}}, InputL};
                        shiftRNext = {{(WORD_W-1){1'b0}}, InputR};
                        bitCntNext = CNT_W'(1);
                    end else begin
                        shiftLNext = {shiftL[WORD_W-2:0], InputL};
                        shiftRNext = {shiftR[WORD_W-2:0], InputR};
                        if (bitCnt == LAST_BIT) begin
                            wordDone   = 1'b1;
                            bitCntNext = '0;
                            stateNext  = IDLE;
                        end else begin
                            bitCntNext = bitCnt + 1'b1;
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign loadWord = wordDone && (!out_valid || out_ready);

    always_ff @(posedge Dclk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge Dclk) begin
        if (Reset) begin
            bitCnt    <= '0;
            shiftL    <= '0;
            shiftR    <= '0;
            dataL     <= '0;
            dataR     <= '0;
            padL      <= 1'b0;
            padR      <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            bitCnt    <= bitCntNext;
            shiftL    <= shiftLNext;
            shiftR    <= shiftRNext;
            frame_err <= resync;
            if (enable) begin
                if (loadWord) begin
                    dataL     <= shiftLNext;
                    dataR     <= shiftRNext;
                    padL      <= shiftLNext[WORD_W-1];
                    padR      <= shiftRNext[WORD_W-1];
                    out_valid <= 1'b1;
                end else if (wordDone) begin
                    overrun <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef ZERO_DETECT_EN
    localparam int ZW = $clog2(ZERO_LIMIT + 1);
    localparam logic [ZW-1:0] ZLIM = ZW'(ZERO_LIMIT);

    logic [ZW-1:0] zeroCnt;
    logic          zeroWord;

    assign zeroWord = (shiftLNext == '0) && (shiftRNext == '0);

    // Only words actually loaded into the output stage count toward sleep
    always_ff @(posedge Dclk) begin
        if (Reset) begin
            zeroCnt <= '0;
            sleep   <= 1'b0;
        end else if (enable) begin
            if (loadWord && !zeroWord) begin
                zeroCnt <= '0;
                sleep   <= 1'b0;
            end else begin
                if (loadWord && zeroCnt != ZLIM) begin
                    zeroCnt <= zeroCnt + 1'b1;
                end
                if (zeroCnt == ZLIM) begin
                    sleep <= 1'b1;
                end
            end
        end
    end
`endif

endmodule
